// File: rtl/dm_cache_wt.sv
// dm_cache_wt: direct-mapped, write-through, no-write-allocate byte cache.
//
// 64 lines x 4 bytes. Read hits return data combinationally in the same
// cycle. A read miss fetches the whole line from memory and then hits on
// the cycle after the refill. Every byte write goes straight to memory
// through a registered port, and also patches the cached byte on a hit.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   addr_from_cpu     byte address (tag | index | offset)
//   rreq_from_cpu     read request, level, held until hit_to_cpu
//   wreq_from_cpu     write request, level (wins over a concurrent read)
//   wdata_from_cpu    write byte
//   rdata_to_cpu      read byte, 0 unless hit_to_cpu
//   hit_to_cpu        lookup hit / request complete (IDLE only)
//   rreq_to_mem       one-cycle line read request
//   raddr_to_mem      line-aligned read address
//   rdata_from_mem    refill line, byte 0 in bits [7:0]
//   rvalid_from_mem   refill data valid, one cycle
//   wreq_to_mem       registered byte write request
//   waddr_to_mem      byte write address
//   wdata_to_mem      byte write data
module dm_cache_wt #(
  parameter int ADDR_W  = 13,
  parameter int INDEX_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_from_cpu,
  input  logic              rreq_from_cpu,
  input  logic              wreq_from_cpu,
  input  logic [7:0]        wdata_from_cpu,
  output logic [7:0]        rdata_to_cpu,
  output logic              hit_to_cpu,
  output logic              rreq_to_mem,
  output logic [ADDR_W-1:0] raddr_to_mem,
  input  logic [31:0]       rdata_from_mem,
  input  logic              rvalid_from_mem,
  output logic              wreq_to_mem,
  output logic [ADDR_W-1:0] waddr_to_mem,
  output logic [7:0]        wdata_to_mem
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    REFILL
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_array  [LINES];
  logic [31:0]      data_array [LINES];

  // Line being refilled, latched when the miss is detected.
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_index;
  logic [31:0]        refill_data;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [1:0]         req_offset;
  logic [31:0]        req_line;
  logic               in_idle;
  logic               lookup_hit;
  logic               start_miss;
  logic               issue_write;

  assign req_tag    = addr_from_cpu[ADDR_W-1 -: TAG_W];
  assign req_index  = addr_from_cpu[INDEX_W+1:2];
  assign req_offset = addr_from_cpu[1:0];
  assign req_line   = data_array[req_index];

  assign in_idle     = (state == IDLE);
  assign lookup_hit  = valid[req_index] && (tag_array[req_index] == req_tag);
  // A concurrent write takes priority, so a read only misses when alone.
  assign start_miss  = in_idle && rreq_from_cpu && !wreq_from_cpu && !lookup_hit;
  assign issue_write = in_idle && wreq_from_cpu;

  // Lookup outputs are forced low during reset, even if the arrays hold junk.
  assign hit_to_cpu   = !reset && in_idle && (rreq_from_cpu || wreq_from_cpu) && lookup_hit;
  assign rdata_to_cpu = hit_to_cpu ? req_line[{req_offset, 3'b000} +: 8] : 8'h00;

  // MISS_REQ lasts exactly one cycle, so this is a single-cycle pulse.
  assign rreq_to_mem  = !reset && (state == MISS_REQ);
  assign raddr_to_mem = {miss_tag, miss_index, 2'b00};

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:      if (start_miss)      state_next = MISS_REQ;
      MISS_REQ:                       state_next = MISS_WAIT;
      MISS_WAIT: if (rvalid_from_mem) state_next = REFILL;
      REFILL:                         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Control state: FSM, valid bits, miss line address and the write port.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state        <= IDLE;
      valid        <= '0;
      miss_tag     <= '0;
      miss_index   <= '0;
      wreq_to_mem  <= 1'b0;
      waddr_to_mem <= '0;
      wdata_to_mem <= 8'h00;
    end else begin
      state       <= state_next;
      wreq_to_mem <= issue_write;
      if (issue_write) begin
        waddr_to_mem <= addr_from_cpu;
        wdata_to_mem <= wdata_from_cpu;
      end
      if (start_miss) begin
        miss_tag   <= req_tag;
        miss_index <= req_index;
      end
      if (state == REFILL) valid[miss_index] <= 1'b1;
    end
  end

  // Storage arrays and the refill holding register.
  // NOTE: no reset here; cleared valid bits make the stale contents unreachable.
  always_ff @(posedge clk) begin
    if (state == MISS_WAIT && rvalid_from_mem) refill_data <= rdata_from_mem;
    if (state == REFILL) begin
      tag_array[miss_index]  <= miss_tag;
      data_array[miss_index] <= refill_data;
    end else if (issue_write && lookup_hit) begin
      data_array[req_index][{req_offset, 3'b000} +: 8] <= wdata_from_cpu;
    end
  end

endmodule

// File: tb/tb_dm_cache_wt.sv
// Directed testbench for dm_cache_wt. A small byte-addressed memory model
// answers line reads after a programmable latency and absorbs posted byte
// writes. Each scenario task checks its own expected values inline.
module tb_dm_cache_wt;

  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] addr_from_cpu;
  logic              rreq_from_cpu;
  logic              wreq_from_cpu;
  logic [7:0]        wdata_from_cpu;
  logic [7:0]        rdata_to_cpu;
  logic              hit_to_cpu;
  logic              rreq_to_mem;
  logic [ADDR_W-1:0] raddr_to_mem;
  logic [31:0]       rdata_from_mem;
  logic              rvalid_from_mem;
  logic              wreq_to_mem;
  logic [ADDR_W-1:0] waddr_to_mem;
  logic [7:0]        wdata_to_mem;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dm_cache_wt #(.ADDR_W(ADDR_W), .INDEX_W(6)) dut (
    .clk             (clk),
    .reset           (reset),
    .addr_from_cpu   (addr_from_cpu),
    .rreq_from_cpu   (rreq_from_cpu),
    .wreq_from_cpu   (wreq_from_cpu),
    .wdata_from_cpu  (wdata_from_cpu),
    .rdata_to_cpu    (rdata_to_cpu),
    .hit_to_cpu      (hit_to_cpu),
    .rreq_to_mem     (rreq_to_mem),
    .raddr_to_mem    (raddr_to_mem),
    .rdata_from_mem  (rdata_from_mem),
    .rvalid_from_mem (rvalid_from_mem),
    .wreq_to_mem     (wreq_to_mem),
    .waddr_to_mem    (waddr_to_mem),
    .wdata_to_mem    (wdata_to_mem)
  );

  // Memory model: rvalid comes mem_lat cycles after the rreq_to_mem cycle.
  logic [7:0]        mem [0:8191];
  int                mem_lat = 2;
  logic              mdl_rvalid = 1'b0;
  logic [31:0]       mdl_rdata = '0;
  logic              mdl_pending = 1'b0;
  logic [ADDR_W-1:0] mdl_addr = '0;
  int                mdl_cnt = 0;
  logic              man_rvalid = 1'b0;
  logic [31:0]       man_rdata = '0;

  assign rvalid_from_mem = mdl_rvalid | man_rvalid;
  assign rdata_from_mem  = man_rvalid ? man_rdata : mdl_rdata;

  always @(posedge clk) begin
    mdl_rvalid <= 1'b0;
    if (wreq_to_mem) mem[waddr_to_mem] <= wdata_to_mem;
    if (rreq_to_mem) begin
      mdl_pending <= 1'b1;
      mdl_addr    <= raddr_to_mem;
      mdl_cnt     <= mem_lat - 1;
    end else if (mdl_pending) begin
      if (mdl_cnt <= 1) begin
        mdl_rvalid  <= 1'b1;
        mdl_rdata   <= {mem[{mdl_addr[12:2], 2'd3}], mem[{mdl_addr[12:2], 2'd2}],
                        mem[{mdl_addr[12:2], 2'd1}], mem[{mdl_addr[12:2], 2'd0}]};
        mdl_pending <= 1'b0;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] w);
    mem[{a[12:2], 2'd0}] = w[7:0];
    mem[{a[12:2], 2'd1}] = w[15:8];
    mem[{a[12:2], 2'd2}] = w[23:16];
    mem[{a[12:2], 2'd3}] = w[31:24];
  endtask

  // Hold a read until hit; check data, memory traffic and miss latency.
  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [7:0] exp_data,
                         input bit exp_miss, input string name);
    int                cyc = 0;
    int                pulses = 0;
    logic [ADDR_W-1:0] ra = '0;
    addr_from_cpu = a;
    rreq_from_cpu = 1'b1;
    wreq_from_cpu = 1'b0;
    #1;
    while (!hit_to_cpu && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (rreq_to_mem) begin
        pulses++;
        ra = raddr_to_mem;
      end
    end
    total++;
    if (hit_to_cpu !== 1'b1) $display("FAIL %s hit: got %b after %0d cycles, want 1", name, hit_to_cpu, cyc);
    else passed++;
    total++;
    if (rdata_to_cpu !== exp_data) $display("FAIL %s rdata: got %h want %h", name, rdata_to_cpu, exp_data);
    else passed++;
    total++;
    if (pulses !== (exp_miss ? 1 : 0)) $display("FAIL %s mem_reads: got %0d want %0d", name, pulses, exp_miss ? 1 : 0);
    else passed++;
    if (exp_miss) begin
      total++;
      if (ra !== {a[12:2], 2'b00}) $display("FAIL %s raddr: got %h want %h", name, ra, {a[12:2], 2'b00});
      else passed++;
      total++;
      if (cyc !== mem_lat + 3) $display("FAIL %s latency: got %0d want %0d", name, cyc, mem_lat + 3);
      else passed++;
    end
    rreq_from_cpu = 1'b0;
    @(posedge clk); #1;
  endtask

  // One-cycle write; checks hit flag and the registered memory write.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [7:0] d,
                          input logic exp_hit, input string name);
    addr_from_cpu  = a;
    wdata_from_cpu = d;
    wreq_from_cpu  = 1'b1;
    #1;
    total++;
    if (hit_to_cpu !== exp_hit) $display("FAIL %s hit: got %b want %b", name, hit_to_cpu, exp_hit);
    else passed++;
    @(posedge clk); #1;
    wreq_from_cpu = 1'b0;
    rreq_from_cpu = 1'b0;
    #1;
    total++;
    if ({wreq_to_mem, waddr_to_mem, wdata_to_mem} !== {1'b1, a, d})
      $display("FAIL %s mem_write: got %b/%h/%h want 1/%h/%h", name, wreq_to_mem, waddr_to_mem, wdata_to_mem, a, d);
    else passed++;
    total++;
    if (rreq_to_mem !== 1'b0) $display("FAIL %s no_mem_read: got %b want 0", name, rreq_to_mem);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (wreq_to_mem !== 1'b0) $display("FAIL %s write_done: got %b want 0", name, wreq_to_mem);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    addr_from_cpu = 13'h0005;
    rreq_from_cpu = 1'b1;
    wreq_from_cpu = 1'b0;
    wdata_from_cpu = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({hit_to_cpu, rdata_to_cpu, rreq_to_mem, raddr_to_mem} !== '0)
      $display("FAIL reset_lookup: got hit=%b rdata=%h rreq=%b raddr=%h want all 0",
               hit_to_cpu, rdata_to_cpu, rreq_to_mem, raddr_to_mem);
    else passed++;
    total++;
    if ({wreq_to_mem, waddr_to_mem, wdata_to_mem} !== '0)
      $display("FAIL reset_write_port: got %b/%h/%h want 0/0/0", wreq_to_mem, waddr_to_mem, wdata_to_mem);
    else passed++;
    rreq_from_cpu = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss_then_hit();
    do_read(13'h0005, 8'h22, 1'b1, "t1_miss_0005");
    do_read(13'h0007, 8'h44, 1'b0, "t1_hit_0007");
  endtask

  task automatic test_write_miss();
    do_write(13'h1F00, 8'hFF, 1'b0, "t2_write_miss");
    do_read(13'h1F00, 8'hFF, 1'b1, "t2_read_after");
  endtask

  task automatic test_write_hit();
    do_read(13'h1F04, 8'hB0, 1'b1, "t3_fill_1F04");
    do_write(13'h1F05, 8'hFF, 1'b1, "t3_write_hit");
    do_read(13'h1F05, 8'hFF, 1'b0, "t3_read_hit");
  endtask

  task automatic test_conflict();
    do_read(13'h1F08, 8'hC0, 1'b1, "t4_fill_1F08");
    do_read(13'h0008, 8'hD0, 1'b1, "t4_evict_0008");
    do_read(13'h1F08, 8'hC0, 1'b1, "t4_refill_1F08");
  endtask

  task automatic test_rw_collision();
    rreq_from_cpu = 1'b1;
    do_write(13'h0010, 8'hAB, 1'b0, "t5_rw_write");
    // Spurious refill data while idle must be ignored.
    man_rdata  = 32'hDEADBEEF;
    man_rvalid = 1'b1;
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    total++;
    if ({hit_to_cpu, rreq_to_mem} !== 2'b00)
      $display("FAIL t5_spurious_rvalid: got hit=%b rreq=%b want 0/0", hit_to_cpu, rreq_to_mem);
    else passed++;
    do_read(13'h0010, 8'hAB, 1'b1, "t5_read_after");
  endtask

  task automatic test_reset_mid_miss();
    mem_lat = 4;
    addr_from_cpu = 13'h0020;
    rreq_from_cpu = 1'b1;
    #1;
    total++;
    if (hit_to_cpu !== 1'b0) $display("FAIL t6_initial_miss: got %b want 0", hit_to_cpu);
    else passed++;
    @(posedge clk); #1;              // MISS_REQ
    total++;
    if ({rreq_to_mem, raddr_to_mem} !== {1'b1, 13'h0020})
      $display("FAIL t6_mem_req: got %b/%h want 1/0020", rreq_to_mem, raddr_to_mem);
    else passed++;
    // A write arriving outside IDLE is dropped.
    wreq_from_cpu  = 1'b1;
    wdata_from_cpu = 8'h99;
    @(posedge clk); #1;              // MISS_WAIT
    total++;
    if ({hit_to_cpu, wreq_to_mem} !== 2'b00)
      $display("FAIL t6_busy_write: got hit=%b wreq=%b want 0/0", hit_to_cpu, wreq_to_mem);
    else passed++;
    wreq_from_cpu = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;              // IDLE, still in reset
    total++;
    if ({hit_to_cpu, rdata_to_cpu, rreq_to_mem} !== '0)
      $display("FAIL t6_in_reset: got hit=%b rdata=%h rreq=%b want 0", hit_to_cpu, rdata_to_cpu, rreq_to_mem);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    rreq_from_cpu = 1'b0;
    repeat (2) @(posedge clk);       // late rvalid arrives while idle
    #1;
    total++;
    if ({hit_to_cpu, rdata_to_cpu, rreq_to_mem, raddr_to_mem, wreq_to_mem, waddr_to_mem, wdata_to_mem} !== '0)
      $display("FAIL t6_after_reset: got hit=%b rdata=%h rreq=%b raddr=%h wreq=%b waddr=%h wdata=%h want all 0",
               hit_to_cpu, rdata_to_cpu, rreq_to_mem, raddr_to_mem, wreq_to_mem, waddr_to_mem, wdata_to_mem);
    else passed++;
    do_read(13'h0020, 8'h55, 1'b1, "t6_reread_0020");
    do_read(13'h1F05, 8'hFF, 1'b1, "t6_lines_invalid");
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7);
    preload(13'h0004, 32'h44332211);
    preload(13'h1F00, 32'hA3A2A1A0);
    preload(13'h1F04, 32'hB3B2B1B0);
    preload(13'h1F08, 32'hC3C2C1C0);
    preload(13'h0008, 32'hD3D2D1D0);
    preload(13'h0010, 32'hE3E2E1E0);
    preload(13'h0020, 32'h88776655);

    test_reset();
    test_read_miss_then_hit();
    test_write_miss();
    test_write_hit();
    test_conflict();
    test_rw_collision();
    test_reset_mid_miss();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dm_cache_wt.md
Name: dm_cache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate byte cache between the test driver/CPU and the memory wrapper.
- Serves byte reads from a 64-line × 4-byte store and refills a whole line from memory on a miss.
- Sends every byte write straight through to memory, and also updates the cached line when the address hits.
- Drop-in consumer of the driver's rreq/wreq/addr/wdata interface; producer of the memory wrapper's rreq/raddr and wreq/waddr/wdata interface.

Parameters:
- ADDR_W, 13, byte address width.
- INDEX_W, 6, line index width (2^INDEX_W lines). Line size is fixed at 4 bytes (offset 2 bits), so tag width = ADDR_W-INDEX_W-2 = 5.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- addr_from_cpu  in  ADDR_W  byte address
- rreq_from_cpu  in  1  read request, level, held until hit_to_cpu
- wreq_from_cpu  in  1  write request, level
- wdata_from_cpu  in  8  write byte
- rdata_to_cpu  out  8  read byte
- hit_to_cpu  out  1  lookup hit / request complete
- rreq_to_mem  out  1  line read request, one-cycle pulse
- raddr_to_mem  out  ADDR_W  line-aligned read address
- rdata_from_mem  in  32  refill line, byte 0 = bits[7:0]
- rvalid_from_mem  in  1  refill data valid, one cycle
- wreq_to_mem  out  1  byte write request
- waddr_to_mem  out  ADDR_W  byte write address
- wdata_to_mem  out  8  write byte

Behaviour:
- Clock and reset: reset is reset, synchronous, active-high; clock is clk.
- Reset values:
  - All 64 valid bits cleared; FSM goes to IDLE.
  - rreq_to_mem=0, raddr_to_mem=0, wreq_to_mem=0, waddr_to_mem=0, wdata_to_mem=0.
  - hit_to_cpu=0, rdata_to_cpu=0 (forced to 0 while in reset).
  - Tag and data arrays need no reset.
- Address split: tag=addr[12:8], index=addr[7:2], offset=addr[1:0].
- Lookup (combinational, IDLE only): hit = valid[index] && tag_array[index]==tag.
  - hit_to_cpu = (rreq_from_cpu|wreq_from_cpu) && hit && state==IDLE.
  - rdata_to_cpu = data_array[index] byte[offset] when hit_to_cpu, else 0.
- FSM states: IDLE, MISS_REQ, MISS_WAIT, REFILL.
  - IDLE, read hit: stay in IDLE; zero-latency data in the same cycle.
  - IDLE, rreq && !wreq && !hit: go to MISS_REQ; latch the line address {tag,index,2'b00}.
  - MISS_REQ: rreq_to_mem=1 for exactly one cycle, raddr_to_mem = latched line address; then go to MISS_WAIT.
  - MISS_WAIT: hold until rvalid_from_mem=1; capture rdata_from_mem; go to REFILL.
  - REFILL: write data_array[index], tag_array[index] and set valid[index]; go to IDLE.
  - The next cycle in IDLE hits. Read-miss latency from request to hit_to_cpu = memory latency + 3 cycles.
- Writes, IDLE only:
  - Each cycle wreq_from_cpu=1, register wreq_to_mem=1 with waddr_to_mem=addr and wdata_to_mem=wdata, so memory sees it 1 cycle later.
  - Memory writes are posted and always accepted.
  - On a write hit, also update the addressed byte in data_array in the same edge.
  - On a write miss: no allocate, no array change, hit_to_cpu=0.
  - A write held for several cycles repeats an identical idempotent memory write.
- Simultaneous rreq and wreq: handled as a write; the read is ignored that cycle.
- Requests arriving outside IDLE: ignored; hit_to_cpu=0; wreq_to_mem=0.
- rvalid_from_mem outside MISS_WAIT: ignored.
- Reset during MISS_WAIT: return to IDLE with all lines invalid; a late rvalid is dropped.
- Eviction: a refill overwrites the line regardless of the old tag. No write-back is needed (write-through).

Test Plan:
1. After reset, read 0x0005 (memory line 0x0004 = 0x44332211): rreq_to_mem pulses once with raddr 0x0004; after rvalid, hit_to_cpu=1 with rdata 0x22. Immediate re-read of 0x0007 hits in the same cycle with 0x44 and no memory request.
2. Write 0xFF to 0x1F00 with line 0x1F00 not cached: wreq_to_mem=1, waddr 0x1F00, wdata 0xFF one cycle later; hit_to_cpu=0. A subsequent read of 0x1F00 misses, refills, and returns 0xFF.
3. Cache line 0x1F04, then write 0xFF to 0x1F05: hit_to_cpu=1 during the write and memory write issued. A read of 0x1F05 hits with 0xFF without a memory read.
4. Conflict: cache 0x1F08, then read 0x0008 (same index 2, tag 0): refill from 0x0008. A read of 0x1F08 then misses and refills again.
5. rreq and wreq both high at 0x0010: only a memory write occurs, no rreq_to_mem. A spurious rvalid_from_mem in IDLE changes nothing.
6. Assert reset while in MISS_WAIT, then deliver rvalid: FSM in IDLE, all outputs 0. A re-read of the same address misses and issues a fresh rreq_to_mem.
